// File: rtl/store_activation_pkg.sv
// ============================================================================
// Module : store_activation_pkg
// Brief  : Shared widths and state encoding for the activation store path.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package store_activation_pkg;

  localparam int BRAM_ADDR_BIT_DEF = 32;
  localparam int BRAM_WIDTH_DEF    = 32;
  localparam int WEIGHT_WIDTH_DEF  = 8;
  localparam int BRAM_BYTE_DEF     = BRAM_WIDTH_DEF / 8;

  localparam int DIM_BIT   = 12;
  localparam int TOTAL_BIT = 3 * DIM_BIT;

  localparam logic [1:0] STATE_IDLE  = 2'd0;
  localparam logic [1:0] STATE_RUN   = 2'd1;
  localparam logic [1:0] STATE_FLUSH = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = STATE_IDLE,
    S_RUN   = STATE_RUN,
    S_FLUSH = STATE_FLUSH
  } state_t;

endpackage

`default_nettype wire

// File: rtl/store_activation_byte_pack_buf.sv
// ============================================================================
// Module : byte_pack_buf
// Brief  : Packs byte beats into BRAM words and emits one registered write
//          per word, with byte enables for partial leading/trailing words.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module byte_pack_buf
  import store_activation_pkg::*;
#(
  parameter int ADDR_BIT   = BRAM_ADDR_BIT_DEF,
  parameter int DATA_WIDTH = BRAM_WIDTH_DEF,
  parameter int LANE_WIDTH = WEIGHT_WIDTH_DEF,
  parameter int NUM_LANE   = DATA_WIDTH / LANE_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [ADDR_BIT-1:0]   base,
  input  logic                  push,
  input  logic [LANE_WIDTH-1:0] data,
  input  logic                  last,
  output logic                  wr_valid,
  output logic [ADDR_BIT-1:0]   wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic [NUM_LANE-1:0]   wr_mask
);

  localparam int LANE_BIT = $clog2(NUM_LANE);

  logic [DATA_WIDTH-1:0] r_pack;
  logic [NUM_LANE-1:0]   r_mask;
  logic [ADDR_BIT-1:0]   r_byte_addr;

  logic [LANE_BIT-1:0]   w_lane;
  logic [DATA_WIDTH-1:0] w_pack_next;
  logic [NUM_LANE-1:0]   w_mask_next;
  logic                  w_flush;

  // The incoming byte is merged before the flush decision so the emitted word
  // already contains it.
  always_comb begin
    w_lane      = r_byte_addr[LANE_BIT-1:0];
    w_pack_next = r_pack;
    w_mask_next = r_mask;
    w_pack_next[w_lane*LANE_WIDTH +: LANE_WIDTH] = data;
    w_mask_next[w_lane] = 1'b1;
    w_flush     = push && ((&w_lane) || last);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pack      <= '0;
      r_mask      <= '0;
      r_byte_addr <= '0;
      wr_valid    <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      wr_mask     <= '0;
    end else begin
      wr_valid <= w_flush;
      wr_mask  <= w_flush ? w_mask_next : '0;
      wr_data  <= w_flush ? w_pack_next : '0;
      if (w_flush) begin
        wr_addr <= {r_byte_addr[ADDR_BIT-1:LANE_BIT], {LANE_BIT{1'b0}}};
      end
      if (load) begin
        r_byte_addr <= base;
        r_pack      <= '0;
        r_mask      <= '0;
      end else if (push) begin
        r_byte_addr <= r_byte_addr + ADDR_BIT'(1);
        r_pack      <= w_flush ? '0 : w_pack_next;
        r_mask      <= w_flush ? '0 : w_mask_next;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/store_activation.sv
// ============================================================================
// Module : store_activation
// Brief  : Streams 8-bit output activations into BRAM through the byte-write
//          port starting at an arbitrary byte address.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module store_activation
  import store_activation_pkg::*;
#(
  parameter int BRAM_ADDR_BIT = BRAM_ADDR_BIT_DEF,
  parameter int BRAM_WIDTH    = BRAM_WIDTH_DEF,
  parameter int WEIGHT_WIDTH  = WEIGHT_WIDTH_DEF,
  parameter int BRAM_BYTE     = BRAM_WIDTH / 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     store_start,
  input  logic [BRAM_ADDR_BIT-1:0] base_addr,
  input  logic [DIM_BIT-1:0]       out_width,
  input  logic [DIM_BIT-1:0]       out_height,
  input  logic [DIM_BIT-1:0]       out_channel,
  input  logic                     px_valid,
  input  logic [WEIGHT_WIDTH-1:0]  px_data,
  output logic                     px_ready,
  output logic                     busy,
  output logic                     done,
  output logic                     BRAM_clk,
  output logic                     BRAM_en,
  output logic                     BRAM_rst,
  output logic [BRAM_ADDR_BIT-1:0] BRAM_addr,
  output logic [BRAM_WIDTH-1:0]    BRAM_din,
  output logic [BRAM_BYTE-1:0]     BRAM_wen
);

  state_t               r_state;
  state_t               w_state_next;
  logic [TOTAL_BIT-1:0] r_total;
  logic [TOTAL_BIT-1:0] r_count;
  logic [TOTAL_BIT-1:0] w_total;
  logic                 w_load;
  logic                 w_push;
  logic                 w_last;
  logic                 r_done;
  logic                 w_wr_valid;
  logic [BRAM_BYTE-1:0] w_wr_mask;

  always_comb begin
    w_total      = TOTAL_BIT'(out_width) * TOTAL_BIT'(out_height) * TOTAL_BIT'(out_channel);
    w_load       = (r_state == S_IDLE) && store_start;
    w_push       = (r_state == S_RUN) && px_valid;
    w_last       = (r_count == r_total - TOTAL_BIT'(1));
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (store_start && (w_total != '0)) w_state_next = S_RUN;
      S_RUN:   if (w_push && w_last) w_state_next = S_FLUSH;
      S_FLUSH: w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_total <= '0;
      r_count <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      // An empty map completes from IDLE without ever entering RUN.
      r_done  <= (r_state == S_FLUSH) || (w_load && (w_total == '0));
      if (w_load) begin
        r_total <= w_total;
        r_count <= '0;
      end else if (w_push) begin
        r_count <= r_count + TOTAL_BIT'(1);
      end
    end
  end

  byte_pack_buf #(
    .ADDR_BIT   (BRAM_ADDR_BIT),
    .DATA_WIDTH (BRAM_WIDTH),
    .LANE_WIDTH (WEIGHT_WIDTH),
    .NUM_LANE   (BRAM_BYTE)
  ) u_pack (
    .clk      (clk),
    .rst      (rst),
    .load     (w_load),
    .base     (base_addr),
    .push     (w_push),
    .data     (px_data),
    .last     (w_last),
    .wr_valid (w_wr_valid),
    .wr_addr  (BRAM_addr),
    .wr_data  (BRAM_din),
    .wr_mask  (w_wr_mask)
  );

  assign px_ready = (r_state == S_RUN);
  assign busy     = (r_state != S_IDLE);
  assign done     = r_done;
  assign BRAM_wen = w_wr_valid ? w_wr_mask : '0;
  assign BRAM_clk = clk;
  assign BRAM_en  = 1'b1;
  assign BRAM_rst = 1'b0;

endmodule

`default_nettype wire

// File: tb/tb_store_activation.sv
// ============================================================================
// Module : tb_store_activation
// Brief  : Self-checking bench for store_activation with a word-grouping model.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_store_activation;

  logic        clk = 1'b0;
  logic        rst;
  logic        store_start;
  logic [31:0] base_addr;
  logic [11:0] out_width, out_height, out_channel;
  logic        px_valid;
  logic [7:0]  px_data;
  logic        px_ready, busy, done;
  logic        BRAM_clk, BRAM_en, BRAM_rst;
  logic [31:0] BRAM_addr, BRAM_din;
  logic [3:0]  BRAM_wen;

  always #5 clk = ~clk;

  store_activation dut (
    .clk(clk), .rst(rst), .store_start(store_start), .base_addr(base_addr),
    .out_width(out_width), .out_height(out_height), .out_channel(out_channel),
    .px_valid(px_valid), .px_data(px_data), .px_ready(px_ready), .busy(busy),
    .done(done), .BRAM_clk(BRAM_clk), .BRAM_en(BRAM_en), .BRAM_rst(BRAM_rst),
    .BRAM_addr(BRAM_addr), .BRAM_din(BRAM_din), .BRAM_wen(BRAM_wen)
  );

  typedef struct {
    int          cyc;
    logic [31:0] addr;
    logic [31:0] din;
    logic [3:0]  wen;
  } wr_t;

  wr_t        wr_q[$];
  wr_t        exp_q[$];
  int         acc_q[$];
  int         done_q[$];
  logic [7:0] bytes_q[$];
  int         cyc = 0;
  int         busy_hi = 0;
  int         total = 0;
  int         bad = 0;

  always @(posedge clk) cyc++;

  // Observe the bus mid-cycle: accepted beats, writes, done pulses.
  always @(negedge clk) begin
    if (px_valid && px_ready) acc_q.push_back(cyc);
    if (BRAM_wen != 4'h0) wr_q.push_back('{cyc, BRAM_addr, BRAM_din, BRAM_wen});
    if (done) done_q.push_back(cyc);
    if (busy) busy_hi++;
  end

  task automatic start_store(input logic [31:0] b, input int w, input int h, input int c,
                             output int start_cyc);
    @(posedge clk); #1;
    wr_q.delete(); acc_q.delete(); done_q.delete(); busy_hi = 0;
    store_start = 1'b1; base_addr = b;
    out_width = w[11:0]; out_height = h[11:0]; out_channel = c[11:0];
    start_cyc = cyc;
    @(posedge clk); #1;
    store_start = 1'b0;
    base_addr = $urandom; out_width = 12'($urandom); out_height = 12'($urandom);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    px_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    px_valid = 1'b1; px_data = b;
    @(posedge clk); #1;
    px_valid = 1'b0; px_data = 8'($urandom);
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (done) ok = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Expected writes: consecutive bytes sharing a word address form one write,
  // issued the cycle after the last of them is accepted.
  task automatic build_model(input logic [31:0] b);
    logic [31:0] a, word, din;
    logic [3:0]  wen;
    int          last_k;
    exp_q.delete();
    word = '0; din = '0; wen = '0; last_k = 0;
    for (int k = 0; k < bytes_q.size(); k++) begin
      a = b + 32'(k);
      if (k > 0 && (a & ~32'h3) != word) begin
        exp_q.push_back('{(last_k < acc_q.size()) ? acc_q[last_k] + 1 : -1, word, din, wen});
        din = '0; wen = '0;
      end
      word = a & ~32'h3;
      din[a[1:0]*8 +: 8] = bytes_q[k];
      wen[a[1:0]] = 1'b1;
      last_k = k;
    end
    if (bytes_q.size() > 0)
      exp_q.push_back('{(last_k < acc_q.size()) ? acc_q[last_k] + 1 : -1, word, din, wen});
  endtask

  task automatic test_reset;
    rst = 1'b1; store_start = 0; base_addr = 0; out_width = 0; out_height = 0;
    out_channel = 0; px_valid = 0; px_data = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({px_ready, busy, done, BRAM_wen} !== 7'b0 || BRAM_addr !== 32'h0 || BRAM_din !== 32'h0) begin
      bad++;
      $display("FAIL reset_state: ready=%b busy=%b done=%b wen=%h addr=%h din=%h, all required 0",
               px_ready, busy, done, BRAM_wen, BRAM_addr, BRAM_din);
    end
    total++;
    if (BRAM_en !== 1'b1 || BRAM_rst !== 1'b0 || BRAM_clk !== clk) begin
      bad++;
      $display("FAIL reset_ties: en=%b rst=%b bclk=%b clk=%b, required en=1 rst=0 bclk=clk",
               BRAM_en, BRAM_rst, BRAM_clk, clk);
    end
    @(posedge clk); #1; rst = 1'b0;
  endtask

  task automatic test_aligned;
    int s; bit ok;
    logic [7:0] d[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    start_store(32'h100, 2, 2, 1, s);
    foreach (d[i]) send_byte(d[i], 0);
    wait_done(ok);
    total++;
    if (!ok || wr_q.size() != 1 || acc_q.size() != 4) begin
      bad++;
      $display("FAIL aligned_count: done=%0d writes=%0d accepts=%0d, required done=1 writes=1 accepts=4",
               ok, wr_q.size(), acc_q.size());
    end else begin
      total++;
      if (wr_q[0].addr !== 32'h100 || wr_q[0].din !== 32'h44332211 || wr_q[0].wen !== 4'hF ||
          wr_q[0].cyc != acc_q[3] + 1) begin
        bad++;
        $display("FAIL aligned_write: addr=%h din=%h wen=%h cyc=%0d, required 00000100 44332211 f cyc=%0d",
                 wr_q[0].addr, wr_q[0].din, wr_q[0].wen, wr_q[0].cyc, acc_q[3] + 1);
      end
      total++;
      if (done_q.size() != 1 || done_q[0] != acc_q[3] + 2) begin
        bad++;
        $display("FAIL aligned_done: pulses=%0d first_cyc=%0d, required 1 pulse at cyc %0d",
                 done_q.size(), (done_q.size() > 0) ? done_q[0] : -1, acc_q[3] + 2);
      end
    end
  endtask

  task automatic test_unaligned;
    int s; bit ok;
    logic [7:0] d[3] = '{8'hAA, 8'hBB, 8'hCC};
    start_store(32'h101, 1, 1, 3, s);
    foreach (d[i]) send_byte(d[i], 0);
    wait_done(ok);
    total++;
    if (!ok || wr_q.size() != 1) begin
      bad++;
      $display("FAIL unaligned_count: done=%0d writes=%0d, required done=1 writes=1", ok, wr_q.size());
    end else begin
      total++;
      if (wr_q[0].addr !== 32'h100 || wr_q[0].din !== 32'hCCBBAA00 || wr_q[0].wen !== 4'b1110) begin
        bad++;
        $display("FAIL unaligned_write: addr=%h din=%h wen=%b, required 00000100 ccbbaa00 1110",
                 wr_q[0].addr, wr_q[0].din, wr_q[0].wen);
      end
    end
  endtask

  task automatic test_lead_partial;
    int s; bit ok;
    start_store(32'h102, 1, 6, 1, s);
    for (int i = 1; i <= 6; i++) send_byte(8'(i), 0);
    wait_done(ok);
    total++;
    if (!ok || wr_q.size() != 2 || done_q.size() != 1) begin
      bad++;
      $display("FAIL lead_count: done=%0d writes=%0d pulses=%0d, required 1/2/1", ok, wr_q.size(), done_q.size());
    end else begin
      total++;
      if (wr_q[0].addr !== 32'h100 || wr_q[0].wen !== 4'b1100 || wr_q[0].din !== 32'h02010000) begin
        bad++;
        $display("FAIL lead_first: addr=%h din=%h wen=%b, required 00000100 02010000 1100",
                 wr_q[0].addr, wr_q[0].din, wr_q[0].wen);
      end
      total++;
      if (wr_q[1].addr !== 32'h104 || wr_q[1].wen !== 4'hF || wr_q[1].din !== 32'h06050403) begin
        bad++;
        $display("FAIL lead_second: addr=%h din=%h wen=%b, required 00000104 06050403 1111",
                 wr_q[1].addr, wr_q[1].din, wr_q[1].wen);
      end
    end
  endtask

  task automatic test_gaps;
    int s; bit ok;
    bytes_q.delete();
    for (int i = 0; i < 5; i++) bytes_q.push_back(8'($urandom));
    start_store(32'h0, 5, 1, 1, s);
    foreach (bytes_q[i]) send_byte(bytes_q[i], $urandom_range(0, 3));
    wait_done(ok);
    total++;
    if (!ok || wr_q.size() != 2) begin
      bad++;
      $display("FAIL gaps_count: done=%0d writes=%0d, required done=1 writes=2", ok, wr_q.size());
    end else begin
      total++;
      if (wr_q[0].addr !== 32'h0 || wr_q[0].wen !== 4'hF ||
          wr_q[0].din !== {bytes_q[3], bytes_q[2], bytes_q[1], bytes_q[0]}) begin
        bad++;
        $display("FAIL gaps_first: addr=%h din=%h wen=%b, required 00000000 %h%h%h%h 1111", wr_q[0].addr,
                 wr_q[0].din, wr_q[0].wen, bytes_q[3], bytes_q[2], bytes_q[1], bytes_q[0]);
      end
      total++;
      if (wr_q[1].addr !== 32'h4 || wr_q[1].wen !== 4'b0001 || wr_q[1].din !== {24'h0, bytes_q[4]}) begin
        bad++;
        $display("FAIL gaps_tail: addr=%h din=%h wen=%b, required 00000004 000000%h 0001",
                 wr_q[1].addr, wr_q[1].din, wr_q[1].wen, bytes_q[4]);
      end
    end
  endtask

  task automatic test_zero_dim;
    int s; bit ok;
    start_store(32'h40, 3, 3, 0, s);
    wait_done(ok);
    total++;
    if (!ok || done_q.size() != 1 || done_q[0] != s + 1 || wr_q.size() != 0 || busy_hi != 0) begin
      bad++;
      $display("FAIL zero_dim: pulses=%0d done_cyc=%0d writes=%0d busy_cycles=%0d, required 1 at cyc %0d, 0, 0",
               done_q.size(), (done_q.size() > 0) ? done_q[0] : -1, wr_q.size(), busy_hi, s + 1);
    end
  endtask

  task automatic test_reset_mid;
    int s; bit ok;
    start_store(32'h300, 4, 1, 1, s);
    send_byte(8'h5A, 0);
    send_byte(8'hA5, 0);
    #2 rst = 1'b1;
    #1;
    total++;
    if ({px_ready, busy, done, BRAM_wen} !== 7'b0 || BRAM_addr !== 32'h0 || BRAM_din !== 32'h0) begin
      bad++;
      $display("FAIL rst_mid_outputs: ready=%b busy=%b done=%b wen=%h addr=%h din=%h, all required 0",
               px_ready, busy, done, BRAM_wen, BRAM_addr, BRAM_din);
    end
    @(posedge clk); #1; rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    total++;
    if (wr_q.size() != 0 || done_q.size() != 0) begin
      bad++;
      $display("FAIL rst_mid_quiet: writes=%0d pulses=%0d, required 0 and 0", wr_q.size(), done_q.size());
    end
    start_store(32'h200, 2, 2, 1, s);
    for (int i = 0; i < 4; i++) send_byte(8'hC0 + 8'(i), 0);
    wait_done(ok);
    total++;
    if (!ok || wr_q.size() != 1 || wr_q[0].addr !== 32'h200 || wr_q[0].din !== 32'hC3C2C1C0 ||
        wr_q[0].wen !== 4'hF) begin
      bad++;
      $display("FAIL rst_mid_restart: done=%0d writes=%0d addr=%h din=%h wen=%h, required 1 1 00000200 c3c2c1c0 f",
               ok, wr_q.size(), (wr_q.size() > 0) ? wr_q[0].addr : 32'h0,
               (wr_q.size() > 0) ? wr_q[0].din : 32'h0, (wr_q.size() > 0) ? wr_q[0].wen : 4'h0);
    end
  endtask

  task automatic test_random;
    int s, n, w, h, c; bit ok;
    logic [31:0] b;
    for (int r = 0; r < 8; r++) begin
      w = $urandom_range(1, 3); h = $urandom_range(1, 3); c = $urandom_range(1, 4);
      n = w * h * c;
      b = (r == 0) ? 32'hFFFF_FFFE : $urandom;
      bytes_q.delete();
      for (int i = 0; i < n; i++) bytes_q.push_back(8'($urandom));
      start_store(b, w, h, c, s);
      foreach (bytes_q[i]) send_byte(bytes_q[i], $urandom_range(0, 2));
      wait_done(ok);
      build_model(b);
      total++;
      if (!ok || wr_q.size() != exp_q.size() || acc_q.size() != n) begin
        bad++;
        $display("FAIL rand_count run %0d: done=%0d writes=%0d accepts=%0d, required 1 %0d %0d",
                 r, ok, wr_q.size(), acc_q.size(), exp_q.size(), n);
      end
      for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
        total++;
        if (wr_q[i].addr !== exp_q[i].addr || wr_q[i].din !== exp_q[i].din ||
            wr_q[i].wen !== exp_q[i].wen || wr_q[i].cyc != exp_q[i].cyc) begin
          bad++;
          $display("FAIL rand_write run %0d #%0d: addr=%h din=%h wen=%b cyc=%0d, required %h %h %b cyc=%0d",
                   r, i, wr_q[i].addr, wr_q[i].din, wr_q[i].wen, wr_q[i].cyc,
                   exp_q[i].addr, exp_q[i].din, exp_q[i].wen, exp_q[i].cyc);
        end
      end
      total++;
      if (done_q.size() != 1 || acc_q.size() == 0 || done_q[0] != acc_q[acc_q.size()-1] + 2) begin
        bad++;
        $display("FAIL rand_done run %0d: pulses=%0d first_cyc=%0d, required 1 pulse 2 cycles after last accept",
                 r, done_q.size(), (done_q.size() > 0) ? done_q[0] : -1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_aligned();
    test_unaligned();
    test_lead_partial();
    test_gaps();
    test_zero_dim();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/store_activation.md
Name: store_activation

Overview:
- Write-side counterpart of the activation loader: accepts a stream of 8-bit output activations from the PE/accumulator stage and packs them into 32-bit BRAM words.
- Writes them through the BRAM byte-write port, so the next layer's loader can read the feature map back byte-addressed.
- Handles arbitrary byte-aligned base addresses using partial-word byte enables.
- Writes one flat, channel-interleaved region of out_width*out_height*out_channel bytes.

Parameters:
- BRAM_ADDR_BIT, 32, byte-address width of the BRAM port.
- BRAM_WIDTH, 32, BRAM data width.
- WEIGHT_WIDTH, 8, activation width; one byte lane.
- BRAM_BYTE, BRAM_WIDTH/8, number of byte lanes and width of the write enable.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- store_start  in  1  start pulse; sampled only in IDLE.
- base_addr  in  BRAM_ADDR_BIT  byte address of the first output byte; latched on store_start.
- out_width, out_height, out_channel  in  12 each  output map dimensions; latched on store_start.
- px_valid  in  1  pixel valid.
- px_data  in  WEIGHT_WIDTH  pixel value.
- px_ready  out  1  pixel ready.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle completion pulse.
- BRAM_clk  out  1  tied to clk.
- BRAM_en  out  1  tied to 1.
- BRAM_rst  out  1  tied to 0.
- BRAM_addr  out  BRAM_ADDR_BIT  word-aligned byte address; bits [1:0] are always 0.
- BRAM_din  out  BRAM_WIDTH  write data; byte i is on bits [8i+:8] (little-endian lanes).
- BRAM_wen  out  BRAM_BYTE  per-lane write enable; bit i enables byte i.

Behaviour:
- Reset values: state=IDLE; px_ready=0; busy=0; done=0; BRAM_addr=0; BRAM_din=0; BRAM_wen=0. The pack register, lane mask, byte address and pixel count all clear.
- States: IDLE, RUN, FLUSH.
- IDLE:
  - On store_start, latch base_addr into byte_addr and compute total = out_width*out_height*out_channel (36-bit, unsigned); clear count.
  - If total==0: stay in IDLE, pulse done in the next cycle, issue no write.
  - Otherwise go to RUN.
- RUN:
  - px_ready=1, combinational from state. A beat is accepted when px_valid && px_ready.
  - Accepted beat: pack[lane]=px_data and mask[lane]=1, with lane=byte_addr[1:0]; then byte_addr++ and count++.
  - A write is triggered when lane==3 or when the beat is the last one (count==total-1).
  - Write timing: the beat is accepted in cycle N. In cycle N+1, BRAM_addr={byte_addr[N][31:2],2'b00}, BRAM_din=pack including the new byte, and BRAM_wen=mask including the new bit, held for exactly one cycle. Pack and mask clear in cycle N.
  - Unwritten lanes of BRAM_din are 0 but are not enabled.
  - Throughput is 1 byte/cycle with no stall; a new beat in cycle N+1 starts the next word.
  - On the last beat, go to FLUSH.
- FLUSH:
  - The final write is on the bus; px_ready=0.
  - Next cycle: done=1 for one cycle, return to IDLE. Last accept to done is 2 cycles.
- BRAM_wen=0 in every cycle without a write. No word is written twice within one run.
- A non-aligned base produces a leading partial word (e.g. base[1:0]=2 gives wen 4'b1100). A non-multiple-of-4 tail produces a trailing partial word.
- Address arithmetic wraps modulo 2^BRAM_ADDR_BIT; no range check.
- store_start is ignored in RUN and FLUSH. px_valid is ignored outside RUN.
- Asynchronous rst mid-operation: the partial word is discarded without a write, done is not pulsed, and all outputs return to their reset values immediately.

Decomposition:
- Shared package (activation IO):
  - BRAM_ADDR_BIT, BRAM_WIDTH and WEIGHT_WIDTH defaults.
  - BRAM_BYTE derivation.
  - State encoding localparams: STATE_IDLE=0, STATE_RUN=1, STATE_FLUSH=2.
- One sub-module: byte_pack_buf.
  - Holds the pack register, lane mask and byte-address counter.
  - Inputs: load, base, push, data, last.
  - Outputs: a registered wr_valid/wr_addr/wr_data/wr_mask.
- The top level keeps the FSM, pixel counter and done/ready logic.

Test Plan:
- base=0x100, dims 2x2x1, pixels 11,22,33,44 back-to-back -> one write, addr 0x100, din 0x44332211, wen 4'hF; done 2 cycles after the 4th accept.
- base=0x101, dims 1x1x3, pixels AA,BB,CC -> one write, addr 0x100, din 0xCCBBAA00, wen 4'b1110.
- base=0x102, dims 1x6x1 -> writes (0x100, wen 4'b1100), then (0x104, wen 4'hF); done pulses once.
- base=0, 5 pixels with px_valid gaps of 0-3 idle cycles -> writes (0x0, wen 4'hF), then (0x4, wen 4'b0001) with the correct byte; BRAM_wen=0 during all gaps.
- out_channel=0 -> done one cycle after store_start, no write, busy stays 0.
- rst asserted after 2 of 4 bytes accepted -> no write, outputs at reset values; a fresh start with base 0x200 writes a full word correctly.
